// File: rtl/pending_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module      : pending_priority_encoder
// Description : Registered request-accumulating priority encoder. Request
//               bits are merged into a pending register and their indices are
//               issued one per valid/ready handshake, highest index first
//               (fixed) or with a rotating pointer (round-robin).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   1     rising-edge clock
//   rst_n      in   1     asynchronous active-low reset
//   req_in     in   N     request bits, one per line
//   req_valid  in   1     merge req_in into pending at the clock edge
//   out_idx    out  IDXW  index offered to the consumer
//   out_valid  out  1     out_idx is valid
//   out_ready  in   1     consumer accepts out_idx on out_valid && out_ready
//   pending    out  N     registered pending bit-vector
//   overflow   out  1     one-cycle pulse: a request hit an already-pending bit
// ============================================================================
module pending_priority_encoder #(
    parameter int N           = 8,
    parameter int IDXW        = $clog2(N),
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_in,
    input  logic            req_valid,
    output logic [IDXW-1:0] out_idx,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    pending,
    output logic            overflow
);

    // Output stage states
    localparam logic [0:0] c_ST_EMPTY = 1'b0;
    localparam logic [0:0] c_ST_HOLD  = 1'b1;

    localparam logic [IDXW-1:0] c_IDX_LAST = IDXW'(N - 1);
    localparam logic [N-1:0]    c_ONE      = {{(N-1){1'b0}}, 1'b1};

    logic [0:0]      r_state;
    logic [N-1:0]    r_pending;
    logic [IDXW-1:0] r_out_idx;
    logic            r_overflow;

    logic            w_load;
    logic [N-1:0]    w_rr_mask;
    logic [N-1:0]    w_masked;
    logic [IDXW-1:0] w_sel;
    logic [N-1:0]    w_clear;
    logic [N-1:0]    w_req;
    logic [N-1:0]    w_pending_next;
    logic            w_overflow_next;

    // Highest set index of a vector; ascending scan so the last hit wins.
    function automatic logic [IDXW-1:0] f_highest(input logic [N-1:0] vec);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = IDXW'(i);
            end
        end
        return idx;
    endfunction

    generate
        if (ROUND_ROBIN) begin : g_rr
            logic [IDXW-1:0] r_ptr;

            // Lines at or below the pointer are eligible first.
            always_comb begin
                w_rr_mask = '0;
                for (int i = 0; i < N; i++) begin
                    w_rr_mask[i] = (IDXW'(i) <= r_ptr);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ptr <= c_IDX_LAST;
                end else if (w_load) begin
                    r_ptr <= (w_sel == '0) ? c_IDX_LAST : (w_sel - 1'b1);
                end
            end
        end else begin : g_fixed
            assign w_rr_mask = '1;
        end
    endgenerate

    // An empty masked set means nothing at or below the pointer: wrap to the
    // highest pending line overall. With a full mask this is plain MSB-first.
    assign w_masked = r_pending & w_rr_mask;
    assign w_sel    = (|w_masked) ? f_highest(w_masked) : f_highest(r_pending);

    assign w_load   = ((r_state == c_ST_EMPTY) || out_ready) && (|r_pending);
    assign w_clear  = w_load ? (c_ONE << w_sel) : '0;
    assign w_req    = req_valid ? req_in : '0;

    // Set is applied after clear, so a re-request of the issued line survives.
    assign w_pending_next  = (r_pending & ~w_clear) | w_req;
    assign w_overflow_next = |(w_req & r_pending & ~w_clear);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_EMPTY;
            r_pending  <= '0;
            r_out_idx  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pending  <= w_pending_next;
            r_overflow <= w_overflow_next;
            if (w_load) begin
                r_out_idx <= w_sel;
                r_state   <= c_ST_HOLD;
            end else if ((r_state == c_ST_HOLD) && out_ready) begin
                // Accepted with nothing left: drop valid, keep last index.
                r_state <= c_ST_EMPTY;
            end
        end
    end

    assign out_valid = (r_state == c_ST_HOLD);
    assign out_idx   = r_out_idx;
    assign pending   = r_pending;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pending_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pending_priority_encoder
// Description : Self-checking bench. Three instances (fixed N=8, round-robin
//               N=8, round-robin N=5) share one stimulus stream and are
//               compared every cycle against a behavioural model; directed
//               tables and sequences pin down the documented scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pending_priority_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req_in = '0;
    logic       req_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic [2:0] idx_fix, idx_rr, idx_n5;
    logic       val_fix, val_rr, val_n5;
    logic [7:0] pend_fix, pend_rr;
    logic [4:0] pend_n5;
    logic       ovf_fix, ovf_rr, ovf_n5;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pending_priority_encoder #(.N(8), .ROUND_ROBIN(1'b0)) u_fix (
        .clk(clk), .rst_n(rst_n), .req_in(req_in), .req_valid(req_valid),
        .out_idx(idx_fix), .out_valid(val_fix), .out_ready(out_ready),
        .pending(pend_fix), .overflow(ovf_fix)
    );

    pending_priority_encoder #(.N(8), .ROUND_ROBIN(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n), .req_in(req_in), .req_valid(req_valid),
        .out_idx(idx_rr), .out_valid(val_rr), .out_ready(out_ready),
        .pending(pend_rr), .overflow(ovf_rr)
    );

    pending_priority_encoder #(.N(5), .ROUND_ROBIN(1'b1)) u_n5 (
        .clk(clk), .rst_n(rst_n), .req_in(req_in[4:0]), .req_valid(req_valid),
        .out_idx(idx_n5), .out_valid(val_n5), .out_ready(out_ready),
        .pending(pend_n5), .overflow(ovf_n5)
    );

    // ---------------- behavioural model (one slot per instance) -------------
    bit    mp   [3][8];
    int    midx [3];
    int    mptr [3];
    bit    mval [3];
    bit    movf [3];
    int    mn   [3] = '{8, 8, 5};
    bit    mrr  [3] = '{1'b0, 1'b1, 1'b1};
    string nm   [3] = '{"fix", "rr", "n5"};

    task automatic model_reset(input int k);
        for (int j = 0; j < 8; j++) mp[k][j] = 1'b0;
        midx[k] = 0;
        mval[k] = 1'b0;
        movf[k] = 1'b0;
        mptr[k] = mn[k] - 1;
    endtask

    // Walk downward from the starting line, wrapping modulo n; first hit wins.
    function automatic int pick(input int k);
        int start;
        start = mrr[k] ? mptr[k] : mn[k] - 1;
        for (int s = 0; s < mn[k]; s++) begin
            int j;
            j = (start - s + mn[k]) % mn[k];
            if (mp[k][j]) return j;
        end
        return -1;
    endfunction

    task automatic model_step(input int k);
        bit anyp;
        bit load;
        int sel;
        anyp = 1'b0;
        for (int j = 0; j < mn[k]; j++) anyp = anyp | mp[k][j];
        load = (!mval[k] || out_ready) && anyp;
        sel  = load ? pick(k) : -1;
        movf[k] = 1'b0;
        for (int j = 0; j < mn[k]; j++) begin
            bit r;
            bit clr;
            r   = req_valid && req_in[j];
            clr = (j == sel);
            if (r && mp[k][j] && !clr) movf[k] = 1'b1;
            mp[k][j] = (mp[k][j] && !clr) || r;
        end
        if (load) begin
            midx[k] = sel;
            mval[k] = 1'b1;
            if (mrr[k]) mptr[k] = (sel == 0) ? mn[k] - 1 : sel - 1;
        end else if (mval[k] && out_ready) begin
            mval[k] = 1'b0;
        end
    endtask

    function automatic int model_pend(input int k);
        int v;
        v = 0;
        for (int j = 0; j < mn[k]; j++) if (mp[k][j]) v = v | (1 << j);
        return v;
    endfunction

    // ---------------- checking helpers --------------------------------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 3; k++) begin
            int a_idx;
            int a_val;
            int a_p;
            int a_ovf;
            case (k)
                0: begin a_idx = int'(idx_fix); a_val = int'(val_fix); a_p = int'(pend_fix); a_ovf = int'(ovf_fix); end
                1: begin a_idx = int'(idx_rr);  a_val = int'(val_rr);  a_p = int'(pend_rr);  a_ovf = int'(ovf_rr);  end
                default: begin a_idx = int'(idx_n5); a_val = int'(val_n5); a_p = int'(pend_n5); a_ovf = int'(ovf_n5); end
            endcase
            chk($sformatf("model %s out_valid", nm[k]), a_val, int'(mval[k]));
            chk($sformatf("model %s out_idx", nm[k]), a_idx, midx[k]);
            chk($sformatf("model %s pending", nm[k]), a_p, model_pend(k));
            chk($sformatf("model %s overflow", nm[k]), a_ovf, int'(movf[k]));
        end
    endtask

    // One clock: advance the model with the inputs currently applied, then
    // sample the DUTs 1 time unit after the rising edge.
    task automatic cycle();
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) model_reset(k);
            else        model_step(k);
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic drive(input bit rv, input logic [7:0] rq, input bit rdy);
        req_valid = rv;
        req_in    = rq;
        out_ready = rdy;
        cycle();
    endtask

    task automatic expect_fix(input string tag, input int v, input int idx,
                              input int p, input int ovf);
        chk({tag, " out_valid"}, int'(val_fix), v);
        chk({tag, " out_idx"}, int'(idx_fix), idx);
        chk({tag, " pending"}, int'(pend_fix), p);
        chk({tag, " overflow"}, int'(ovf_fix), ovf);
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) model_reset(k);
        check_model();
        cycle();
        rst_n = 1'b1;
    endtask

    // ---------------- directed table ----------------------------------------
    typedef struct {
        bit         rv;
        logic [7:0] req;
        bit         rdy;
        int         ev;
        int         eidx;
        int         ep;
        int         eovf;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input bit rv, input logic [7:0] rq, input bit rdy,
                           input int ev, input int eidx, input int ep, input int eovf);
        vec_t v;
        v.rv = rv; v.req = rq; v.rdy = rdy;
        v.ev = ev; v.eidx = eidx; v.ep = ep; v.eovf = eovf;
        tbl.push_back(v);
    endtask

    initial begin
        // Fixed priority, 0x55 pulse: 6,4,2,0 starting two edges after request
        add_vec(1'b1, 8'h55, 1'b1, 0, 0, 'h55, 0);
        add_vec(1'b0, 8'h00, 1'b1, 1, 6, 'h15, 0);
        add_vec(1'b0, 8'h00, 1'b1, 1, 4, 'h05, 0);
        add_vec(1'b0, 8'h00, 1'b1, 1, 2, 'h01, 0);
        add_vec(1'b0, 8'h00, 1'b1, 1, 0, 'h00, 0);
        add_vec(1'b0, 8'h00, 1'b1, 0, 0, 'h00, 0);
        // Backpressure: 7 held through the stall, then 7 and 6 issued
        add_vec(1'b1, 8'hC0, 1'b0, 0, 0, 'hC0, 0);
        add_vec(1'b0, 8'h00, 1'b0, 1, 7, 'h40, 0);
        for (int i = 0; i < 4; i++) add_vec(1'b0, 8'h00, 1'b0, 1, 7, 'h40, 0);
        add_vec(1'b0, 8'h00, 1'b1, 1, 6, 'h00, 0);
        add_vec(1'b0, 8'h00, 1'b1, 0, 6, 'h00, 0);
        // req_valid with all-zero req_in changes nothing
        add_vec(1'b1, 8'h00, 1'b1, 0, 6, 'h00, 0);

        // Reset state
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        expect_fix("reset", 0, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rv, tbl[i].req, tbl[i].rdy);
            expect_fix($sformatf("tbl[%0d]", i), tbl[i].ev, tbl[i].eidx, tbl[i].ep, tbl[i].eovf);
        end

        // Merge/overflow: bit 4 requested twice while pending, issued once
        drive(1'b1, 8'h20, 1'b0); expect_fix("merge0", 0, 6, 'h20, 0);
        drive(1'b1, 8'h10, 1'b0); expect_fix("merge1", 1, 5, 'h10, 0);
        drive(1'b1, 8'h10, 1'b0); expect_fix("merge2", 1, 5, 'h10, 1);
        drive(1'b0, 8'h00, 1'b0); expect_fix("merge3", 1, 5, 'h10, 0);
        drive(1'b0, 8'h00, 1'b1); expect_fix("merge4", 1, 4, 'h00, 0);
        drive(1'b0, 8'h00, 1'b1); expect_fix("merge5", 0, 4, 'h00, 0);

        // Set wins over clear: 6 re-requested while being loaded
        drive(1'b1, 8'h40, 1'b1); expect_fix("setwin0", 0, 4, 'h40, 0);
        drive(1'b1, 8'h40, 1'b1); expect_fix("setwin1", 1, 6, 'h40, 0);
        drive(1'b0, 8'h00, 1'b1); expect_fix("setwin2", 1, 6, 'h00, 0);
        drive(1'b0, 8'h00, 1'b1); expect_fix("setwin3", 0, 6, 'h00, 0);

        // Async reset mid-issue with 0x70 pending
        drive(1'b1, 8'hF0, 1'b1); expect_fix("arst0", 0, 6, 'hF0, 0);
        drive(1'b0, 8'h00, 1'b1); expect_fix("arst1", 1, 7, 'h70, 0);
        async_reset();
        expect_fix("arst during", 0, 0, 0, 0);
        drive(1'b0, 8'h00, 1'b1); expect_fix("arst after", 0, 0, 0, 0);

        // Held 0x81: fixed starves 0, round-robin alternates 7,0 from a fresh pointer
        drive(1'b1, 8'h81, 1'b1); expect_fix("rr0", 0, 0, 'h81, 0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'h81, 1'b1);
            expect_fix($sformatf("starve[%0d]", i), 1, 7, 'h81, 1);
            chk($sformatf("rr alt[%0d] out_valid", i), int'(val_rr), 1);
            chk($sformatf("rr alt[%0d] out_idx", i), int'(idx_rr), (i % 2 == 0) ? 7 : 0);
        end
        for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1);

        // Randomised traffic, with occasional asynchronous resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                async_reset();
            end else begin
                drive(1'($urandom_range(0, 1)), 8'($urandom()),
                      ($urandom_range(0, 3) != 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pending_priority_encoder.md
Name: pending_priority_encoder

Overview:
- Parametrised, registered successor to the combinational 8-to-3 priority encoder.
- Accumulates request bits in a pending register and issues their indices one at a time in priority order through a valid/ready output stage.
- Priority is fixed (highest index wins) or round-robin, chosen by parameter.
- Sits between interrupt/request sources and a single consumer that services one index per handshake.

Parameters:
N, 8, number of request lines (N >= 2)
IDXW, $clog2(N), width of issued index
ROUND_ROBIN, 0, 0 = fixed MSB-first priority; 1 = rotating priority

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_in  input  N  request bits, one per line
req_valid  input  1  when 1, req_in is merged into pending at the clock edge
out_idx  output  IDXW  index being offered to the consumer
out_valid  output  1  out_idx is valid
out_ready  input  1  consumer accepts out_idx when out_valid && out_ready
pending  output  N  current pending bit-vector, registered
overflow  output  1  one-cycle pulse: a requested bit was already pending and is merged, not counted twice

Behaviour:
- Reset (rst_n low, asynchronous):
  - pending = 0, out_idx = 0, out_valid = 0, overflow = 0.
  - RR pointer ptr = N-1.
  - Deassertion takes effect at the next clock edge.
- Output stage has two states:
  - EMPTY (out_valid = 0).
  - HOLD (out_valid = 1).
- Load condition: load = (!out_valid || out_ready) && (pending != 0).
- Selection, from the pending register only; req_in is never bypassed:
  - Fixed (ROUND_ROBIN = 0): sel = highest set index of pending.
  - Round-robin (ROUND_ROBIN = 1): sel = highest set index <= ptr. If there is none, sel = highest set index overall (wrap).
- On load:
  - out_idx <= sel and out_valid <= 1.
  - Bit sel is cleared from pending.
  - In RR mode, ptr <= (sel == 0) ? N-1 : sel-1.
  - ptr is unchanged when there is no load.
- When out_valid && out_ready && pending == 0: out_valid <= 0 (EMPTY), and out_idx holds its last value.
- When out_valid && !out_ready: out_idx and out_valid are held stable, and pending only accumulates.
- Pending update:
  - pending_next = (pending & ~(load ? onehot(sel) : 0)) | (req_valid ? req_in : 0).
  - Set wins over clear: a bit re-requested in the same cycle it is loaded stays pending and is issued again later.
- overflow_next = req_valid && |(req_in & pending & ~clear_mask). It is a single-cycle pulse and is not sticky.
- Latency:
  - A request presented at edge k appears in pending after edge k.
  - It can be issued earliest with out_valid high after edge k+1 (two edges from request to offer).
- Throughput: one index per cycle when out_ready is held high and pending is non-empty. There are no bubbles between back-to-back issues.
- A request with req_valid = 1 and req_in = 0 has no effect.
- With N not a power of two, out_idx never exceeds N-1.
- Reset asserted mid-operation clears all state immediately. Any in-flight index is dropped and not re-offered.

Test Plan:
1. Fixed, N=8:
   - Stimulus: req_in=8'b01010101 pulsed one cycle, out_ready=1.
   - Required: out_idx sequence 6, 4, 2, 0 on consecutive cycles, starting two edges after the request; then out_valid=0 and pending=0.
2. Backpressure:
   - Stimulus: req_in=8'b11000000, out_ready=0 for 5 cycles, then 1.
   - Required: out_idx=7 is held stable with out_valid=1 throughout the stall, pending=8'b01000000 during the stall; then 7 and 6 are issued.
3. Merge/overflow:
   - Stimulus: req_in=8'b00010000 on two consecutive cycles while out_ready=0 and bit 4 is pending.
   - Required: overflow pulses 1 for one cycle, and index 4 is issued exactly once.
4. Set-wins-over-clear:
   - Stimulus: re-request bit 6 in the same cycle index 6 is loaded.
   - Required: pending[6]=1 after the edge, and 6 is issued a second time.
5. Round-robin, N=8:
   - Stimulus: hold req_valid=1 with req_in=8'b10000001, out_ready=1.
   - Required: out_idx alternates 7, 0, 7, 0; in fixed mode the same stimulus must issue 7 repeatedly (starvation of 0).
6. Async reset:
   - Stimulus: assert rst_n=0 mid-issue, between clock edges, with pending=8'b01110000.
   - Required: out_valid, pending and overflow go to 0 immediately without waiting for an edge; after release, ptr=N-1 and the first issue follows a fresh request.
